// File: rtl/message_scheduler_pkg.sv
// Shared SHA-256 definitions: word/schedule types, scheduler FSM states,
// round constants and the small-sigma functions used by message expansion.
package sha256_constants;

    typedef logic [0:31]       word_t;
    typedef logic [0:63][0:31] sched_t;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } sched_state_t;

    localparam int unsigned BLOCK_WORDS      = 16;
    localparam logic [5:0]  FIRST_EXPAND_IDX = 6'd16;
    localparam logic [5:0]  LAST_IDX         = 6'd63;

    localparam sched_t k_constants = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // With [0:31] words bit 0 is the MSB, so >> moves toward higher indices,
    // which is exactly the numeric right shift.
    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t sigma0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t sigma1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/message_scheduler_if.sv
// Block-in / schedule-out handshake bundle between the block source,
// the message scheduler and the hasher that consumes the schedule.
import sha256_constants::*;

interface message_scheduler_if;

    logic [0:511] block_in;
    logic         block_valid;
    logic         block_ready;
    sched_t       message_schedule;
    logic         sched_valid;
    logic         sched_ready;
    logic         busy;

    modport master (
        output block_in, block_valid, sched_ready,
        input  block_ready, message_schedule, sched_valid, busy
    );

    modport slave (
        input  block_in, block_valid, sched_ready,
        output block_ready, message_schedule, sched_valid, busy
    );

endinterface

// File: rtl/message_scheduler_sched_word.sv
// One step of SHA-256 message expansion: W[t] from its four predecessor taps.
module sched_word
    import sha256_constants::*;
(
    input  word_t w_m2,
    input  word_t w_m7,
    input  word_t w_m15,
    input  word_t w_m16,
    output word_t w_new
);

    assign w_new = sigma1(w_m2) + w_m7 + sigma0(w_m15) + w_m16;

endmodule

// File: rtl/message_scheduler.sv
// SHA-256 message scheduler: captures a 512-bit block, expands W16..W63 at
// one word per cycle and presents the full 64-word schedule to the hasher.
module message_scheduler
    import sha256_constants::*;
(
    input  logic                clk,
    input  logic                rst,
    message_scheduler_if.slave  bus
);

    sched_state_t state_q, state_d;
    logic [5:0]   idx_q;
    sched_t       sched_q;
    word_t        new_word;

    logic block_ready, busy, sched_valid;
    logic capture, expand_we, release_sched;

    sched_word u_sched_word (
        .w_m2  (sched_q[idx_q - 6'd2]),
        .w_m7  (sched_q[idx_q - 6'd7]),
        .w_m15 (sched_q[idx_q - 6'd15]),
        .w_m16 (sched_q[idx_q - 6'd16]),
        .w_new (new_word)
    );

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d       = state_q;
        block_ready   = 1'b0;
        busy          = 1'b0;
        sched_valid   = 1'b0;
        capture       = 1'b0;
        expand_we     = 1'b0;
        release_sched = 1'b0;
        unique case (state_q)
            IDLE: begin
                block_ready = 1'b1;
                if (bus.block_valid) begin
                    capture = 1'b1;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                busy      = 1'b1;
                expand_we = 1'b1;
                if (idx_q == LAST_IDX) state_d = DONE;
            end
            DONE: begin
                sched_valid = 1'b1;
                if (bus.sched_ready) begin
                    release_sched = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the schedule array is reset because the consumer may observe all 64 words after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= FIRST_EXPAND_IDX;
            sched_q <= '0;
        end else if (capture) begin
            for (int i = 0; i < int'(BLOCK_WORDS); i++) begin
                sched_q[i] <= bus.block_in[i*32 +: 32];
            end
            idx_q <= FIRST_EXPAND_IDX;
        end else if (expand_we) begin
            // idx wraps to 0 after W63; it is reloaded before it is used again
            sched_q[idx_q] <= new_word;
            idx_q          <= idx_q + 6'd1;
        end else if (release_sched) begin
            idx_q <= FIRST_EXPAND_IDX;
        end
    end

    assign bus.block_ready      = block_ready;
    assign bus.busy             = busy;
    assign bus.sched_valid      = sched_valid;
    assign bus.message_schedule = sched_q;

endmodule

// File: tb/tb_message_scheduler.sv
// Self-checking bench for message_scheduler: table of known schedule words
// plus directed sequences for latency, DONE hold, mid-expand reset and streaming.
module tb_message_scheduler;

    logic clk = 1'b0;
    logic rst;

    message_scheduler_if intf ();

    message_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (intf)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          blk_sel;
        int          widx;
        logic [31:0] exp;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    logic [0:511] blk_abc, blk_zero, blk_pat, blk_pat2;
    logic [31:0]  got     [4][64];
    logic [31:0]  model_w [64];
    logic [31:0]  snap    [64];
    vec_t         vecs    [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] s0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    task automatic compute_model(input logic [0:511] blk);
        for (int i = 0; i < 16; i++) model_w[i] = blk[i*32 +: 32];
        for (int i = 16; i < 64; i++)
            model_w[i] = s1(model_w[i-2]) + model_w[i-7] + s0(model_w[i-15]) + model_w[i-16];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic take_snap();
        for (int i = 0; i < 64; i++) snap[i] = intf.message_schedule[i];
    endtask

    function automatic int diff_snap();
        int d = 0;
        for (int i = 0; i < 64; i++)
            if (snap[i] !== 32'(intf.message_schedule[i])) d++;
        return d;
    endfunction

    function automatic int diff_model();
        int d = 0;
        for (int i = 0; i < 64; i++)
            if (model_w[i] !== 32'(intf.message_schedule[i])) d++;
        return d;
    endfunction

    // Accept a block, optionally poke block_valid mid-expand, and wait for sched_valid.
    task automatic run_block(input logic [0:511] blk, input bit disturb, output int lat);
        intf.block_in    = blk;
        intf.block_valid = 1'b1;
        tick();
        intf.block_valid = 1'b0;
        intf.block_in    = ~blk;
        lat = 0;
        while (!intf.sched_valid && lat < 200) begin
            if (disturb && lat == 10) intf.block_valid = 1'b1;
            tick();
            intf.block_valid = 1'b0;
            lat++;
        end
    endtask

    task automatic release_sched();
        intf.sched_ready = 1'b1;
        tick();
        intf.sched_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int t;
        int k;
        int rise [2];
        logic [0:511] stream [2];

        blk_abc  = {32'h61626380, 448'h0, 32'h00000018};
        blk_zero = '0;
        for (int i = 0; i < 16; i++) begin
            blk_pat[i*32 +: 32]  = (32'h9e3779b9 * (i + 1)) ^ 32'(i);
            blk_pat2[i*32 +: 32] = 32'hdeadbeef - 32'(i * 32'h01010101);
        end

        vecs[0]  = '{"abc_w0",   0, 0,  32'h61626380};
        vecs[1]  = '{"abc_w1",   0, 1,  32'h00000000};
        vecs[2]  = '{"abc_w14",  0, 14, 32'h00000000};
        vecs[3]  = '{"abc_w15",  0, 15, 32'h00000018};
        vecs[4]  = '{"abc_w16",  0, 16, 32'h61626380};
        vecs[5]  = '{"abc_w17",  0, 17, 32'h000F0000};
        vecs[6]  = '{"abc_w18",  0, 18, 32'h7DA86405};
        vecs[7]  = '{"abc_w63",  0, 63, 32'h12B1EDEB};
        vecs[8]  = '{"zero_w0",  1, 0,  32'h00000000};
        vecs[9]  = '{"zero_w40", 1, 40, 32'h00000000};
        vecs[10] = '{"zero_w63", 1, 63, 32'h00000000};
        vecs[11] = '{"rst_abc_w16", 3, 16, 32'h61626380};
        vecs[12] = '{"rst_abc_w17", 3, 17, 32'h000F0000};
        vecs[13] = '{"rst_abc_w18", 3, 18, 32'h7DA86405};
        vecs[14] = '{"rst_abc_w63", 3, 63, 32'h12B1EDEB};
        vecs[15] = '{"rst_abc_w0",  3, 0,  32'h61626380};

        // Reset state, observed while reset is still held
        rst              = 1'b1;
        intf.block_in    = '0;
        intf.block_valid = 1'b0;
        intf.sched_ready = 1'b0;
        #12;
        check("rst_block_ready", 32'(intf.block_ready), 32'd1);
        check("rst_sched_valid", 32'(intf.sched_valid), 32'd0);
        check("rst_busy",        32'(intf.busy),        32'd0);
        for (int i = 0; i < 64; i++) snap[i] = '0;
        check("rst_words_zero", 32'(diff_snap()), 32'd0);
        rst = 1'b0;
        tick();

        // IDLE holds with block_valid low
        intf.block_in = blk_pat;
        repeat (3) tick();
        check("idle_hold_ready", 32'(intf.block_ready), 32'd1);
        check("idle_hold_words", 32'(diff_snap()), 32'd0);

        // "abc" block, then DONE hold with a stray block_valid
        run_block(blk_abc, 1'b0, lat);
        check("abc_latency", 32'(lat), 32'd48);
        for (int i = 0; i < 64; i++) got[0][i] = intf.message_schedule[i];
        take_snap();
        for (int c = 0; c < 10; c++) begin
            intf.block_valid = (c == 4);
            intf.block_in    = blk_pat;
            tick();
            check("done_hold_valid", 32'(intf.sched_valid), 32'd1);
            check("done_hold_ready", 32'(intf.block_ready), 32'd0);
            check("done_hold_words", 32'(diff_snap()), 32'd0);
        end
        intf.block_valid = 1'b0;
        release_sched();
        check("release_block_ready", 32'(intf.block_ready), 32'd1);
        check("release_sched_valid", 32'(intf.sched_valid), 32'd0);
        tick();
        check("idle_retains_schedule", 32'(diff_snap()), 32'd0);

        // All-zero block
        run_block(blk_zero, 1'b0, lat);
        check("zero_latency", 32'(lat), 32'd48);
        for (int i = 0; i < 64; i++) got[1][i] = intf.message_schedule[i];
        release_sched();

        // Patterned block with block_valid pulsed during EXPAND
        run_block(blk_pat, 1'b1, lat);
        check("disturb_latency", 32'(lat), 32'd48);
        compute_model(blk_pat);
        check("disturb_schedule_diffs", 32'(diff_model()), 32'd0);
        release_sched();

        // Reset at idx=30: accept edge + 14 expand edges
        intf.block_in    = blk_pat2;
        intf.block_valid = 1'b1;
        tick();
        intf.block_valid = 1'b0;
        repeat (14) tick();
        check("pre_rst_busy", 32'(intf.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_block_ready", 32'(intf.block_ready), 32'd1);
        check("async_rst_busy",        32'(intf.busy),        32'd0);
        check("async_rst_sched_valid", 32'(intf.sched_valid), 32'd0);
        #2;
        rst = 1'b0;
        tick();
        run_block(blk_abc, 1'b0, lat);
        check("post_rst_latency", 32'(lat), 32'd48);
        for (int i = 0; i < 64; i++) got[3][i] = intf.message_schedule[i];
        release_sched();

        // Table of known words
        for (int v = 0; v < 16; v++)
            check(vecs[v].name, got[vecs[v].blk_sel][vecs[v].widx], vecs[v].exp);
        compute_model(blk_abc);
        for (int i = 0; i < 64; i++) snap[i] = got[0][i];
        k = 0;
        for (int i = 0; i < 64; i++) if (snap[i] !== model_w[i]) k++;
        check("abc_full_model", 32'(k), 32'd0);

        // Back-to-back stream with sched_ready tied high
        stream[0]        = blk_pat2;
        stream[1]        = blk_abc;
        rise[0]          = -1;
        rise[1]          = -1;
        k                = 0;
        t                = 0;
        intf.sched_ready = 1'b1;
        intf.block_in    = stream[0];
        intf.block_valid = 1'b1;
        while (k < 2 && t < 400) begin
            tick();
            t++;
            if (intf.sched_valid) begin
                rise[k] = t;
                compute_model(stream[k]);
                check("stream_schedule_diffs", 32'(diff_model()), 32'd0);
                k++;
                if (k < 2) intf.block_in = stream[k];
            end
        end
        intf.block_valid = 1'b0;
        intf.sched_ready = 1'b0;
        check("stream_first_rise", 32'(rise[0]), 32'd49);
        check("stream_period",     32'(rise[1] - rise[0]), 32'd50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/message_scheduler.md
MESSAGE_SCHEDULER -- requirements
Module: message_scheduler

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed by SHA-256.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 block_in  input  512  message block; bits [0:31] are W0, [32:63] are W1, ... [480:511] are W15; bit 0 is the MSB.
REQ-005 block_valid  input  1  block_in is valid for transfer.
REQ-006 block_ready  output  1  the block can accept a block this cycle.
REQ-007 message_schedule  output  32 x 64 array [0:63] of [0:31]  expanded schedule W0..W63, in the form the hasher consumes.
REQ-008 sched_valid  output  1  message_schedule is complete and stable.
REQ-009 sched_ready  input  1  the consumer (hasher) accepts the schedule.
REQ-010 busy  output  1  expansion is in progress.

Function
REQ-011 The FSM SHALL have three states: IDLE, EXPAND and DONE.
REQ-012 block_ready SHALL be 1 only in IDLE; busy SHALL be 1 only in EXPAND; sched_valid SHALL be 1 only in DONE.
REQ-013 In IDLE, when block_valid&&block_ready, the block SHALL capture W0..W15 from block_in, set idx=16 and enter EXPAND.
REQ-014 In IDLE, when block_valid is 0, the block SHALL hold all state.
REQ-015 In EXPAND, each cycle SHALL compute W[idx] = sigma1(W[idx-2]) + W[idx-7] + sigma0(W[idx-15]) + W[idx-16] modulo 2^32, store it, and increment idx.
REQ-016 sigma0(x) SHALL equal ROTR7(x) ^ ROTR18(x) ^ SHR3(x); sigma1(x) SHALL equal ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
REQ-017 ROTR and SHR SHALL be defined on the numeric value, with bit 0 as the MSB; SHR shifts toward the higher index and zero-fills index 0.
REQ-018 The cycle that writes W63 SHALL transition the FSM to DONE.
REQ-019 Latency: exactly 48 EXPAND cycles; sched_valid SHALL rise on the 48th rising edge after the accepting edge.
REQ-020 In DONE, message_schedule and sched_valid SHALL hold stable for as long as sched_ready is 0.
REQ-021 In DONE, when sched_ready is 1, the block SHALL return to IDLE on that edge; sched_valid SHALL be 0 and block_ready SHALL be 1 in the next cycle.
REQ-022 block_valid asserted outside IDLE SHALL be ignored; no capture occurs and no state is corrupted.
REQ-023 message_schedule SHALL retain the last completed schedule from IDLE until the next capture.
REQ-024 Words W16..W63 SHALL be undefined to the consumer while sched_valid is 0.

Reset
REQ-025 When rst is asserted, at any time including mid-EXPAND, the state SHALL become IDLE and idx SHALL become 16, with no clock edge required.
REQ-026 Reset values: block_ready=1, sched_valid=0, busy=0, and all 64 message_schedule words =0.
REQ-027 After rst deasserts, the first capture SHALL follow REQ-013 with no stale words carried over.

Structure
REQ-028 The functions sigma0 and sigma1 and the state enum type SHALL live in the shared package sha256_constants, alongside k_constants.
REQ-029 One sub-module, sched_word, SHALL be instantiated once; it is combinational and takes W[idx-2], W[idx-7], W[idx-15] and W[idx-16] and returns W[idx].
REQ-030 The schedule SHALL be stored as 64 x 32-bit registers, written with an idx-addressed write and read as fixed taps.

Verification
REQ-031 "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018) -> W16=0x61626380, W17=0x000F0000, W18=0x7DA86405, W63=0x12B1EDEB; W0..W15 are unchanged.
REQ-032 All-zero block -> all 64 words are 0x00000000; sched_valid rises exactly 48 cycles after acceptance.
REQ-033 Hold sched_ready=0 for 10 cycles in DONE -> sched_valid=1, block_ready=0 and message_schedule is bit-identical every cycle; raising sched_ready gives block_ready=1 next cycle.
REQ-034 Assert rst while idx=30 -> IDLE immediately, sched_valid=0, busy=0, block_ready=1; a new "abc" block then yields the vectors of REQ-031.
REQ-035 Pulse block_valid with a different block_in during EXPAND and during DONE -> no effect on the result vectors or the 48-cycle latency.
REQ-036 Back-to-back blocks with sched_ready tied to 1 -> one schedule per 50 cycles (capture + 48 EXPAND + DONE), with the correct vectors for each block.
